// File: rtl/jtag_driver_pkg.sv
// Shared types and TAP sequencing constants for the JTAG scan driver.
package jtag_driver_pkg;

   typedef enum logic [2:0] {TLR, IDLE, HDR, SHIFT, TAIL, DONE} jtag_state_e;

   localparam logic [2:0] DR_HDR     = 3'b001;
   localparam int         DR_HDR_LEN = 3;
   localparam logic [3:0] IR_HDR     = 4'b0011;
   localparam int         IR_HDR_LEN = 4;
   localparam int         TLR_LEN    = 6;
   localparam int         TAIL_LEN   = 2;

   // TMS value for header period idx, applied LSB first.
   function automatic logic hdr_tms(input logic ir, input logic [1:0] idx);
      if (ir) return IR_HDR[idx];
      return (idx < 2'(DR_HDR_LEN)) ? DR_HDR[idx] : 1'b0;
   endfunction

   function automatic logic [1:0] hdr_last(input logic ir);
      return ir ? 2'(IR_HDR_LEN - 1) : 2'(DR_HDR_LEN - 1);
   endfunction

endpackage

// File: rtl/jtag_driver_if.sv
// Command/response channel between a scan requester and the JTAG driver.
interface jtag_driver_if #(parameter int MAX_LEN = 32);

   localparam int LEN_W = $clog2(MAX_LEN + 1);

   logic               cmd_valid;
   logic               cmd_ready;
   logic               cmd_ir;
   logic [LEN_W-1:0]   cmd_len;
   logic [MAX_LEN-1:0] cmd_data;
   logic               rsp_valid;
   logic [MAX_LEN-1:0] rsp_data;

   modport master (
      output cmd_valid, cmd_ir, cmd_len, cmd_data,
      input  cmd_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_ir, cmd_len, cmd_data,
      output cmd_ready, rsp_valid, rsp_data
   );

endinterface

// File: rtl/jtag_driver_tck_gen.sv
// TCK divider: toggles every CLK_DIV cycles while run is high, parks low otherwise.
module tck_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic tck,
   output logic rise_tick,
   output logic fall_tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt_q;
   logic          half_end;

   assign half_end  = run && (cnt_q == CW'(CLK_DIV - 1));
   assign rise_tick = half_end && !tck;
   assign fall_tick = half_end && tck;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         tck   <= 1'b0;
      end else if (!run) begin
         cnt_q <= '0;
         tck   <= 1'b0;
      end else if (half_end) begin
         cnt_q <= '0;
         tck   <= ~tck;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/jtag_driver.sv
// JTAG host: turns IR/DR scan commands into TCK/TMS/TDI sequences and returns captured TDO.
module jtag_driver
   import jtag_driver_pkg::*;
#(
   parameter int MAX_LEN = 32,
   parameter int CLK_DIV = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   jtag_driver_if.slave  bus,
   output logic          tck,
   output logic          tms,
   output logic          tdi,
   input  logic          tdo
);

   localparam int LEN_W = $clog2(MAX_LEN + 1);
   localparam int CNT_W = (LEN_W > 3) ? LEN_W : 3;

   jtag_state_e        state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, nxt, len_ext;
   logic               tms_q, tms_d, tdi_q, tdi_d, end_q, end_d;
   logic               ir_q;
   logic [LEN_W-1:0]   len_q, len_clamped;
   logic [MAX_LEN-1:0] sh_q, cap_q, rsp_q;
   logic               run, rise_tick, fall_tick, accept;

   assign accept      = (state_q == IDLE) && bus.cmd_valid;
   assign len_clamped = (bus.cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.cmd_len;
   assign len_ext     = CNT_W'(len_q);
   assign nxt         = cnt_q + 1'b1;
   // end_q parks TCK for the one cycle between the final falling edge and the state change
   assign run         = (state_q inside {TLR, HDR, SHIFT, TAIL}) && !end_q;

   assign bus.cmd_ready = (state_q == IDLE);
   assign bus.rsp_valid = (state_q == DONE);
   assign bus.rsp_data  = rsp_q;
   assign tms           = tms_q;
   assign tdi           = tdi_q;

   tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
      .tck       (tck),
      .rise_tick (rise_tick),
      .fall_tick (fall_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= TLR;
         cnt_q   <= '0;
         tms_q   <= 1'b1;
         tdi_q   <= 1'b0;
         end_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tms_q   <= tms_d;
         tdi_q   <= tdi_d;
         end_q   <= end_d;
      end
   end

   // TMS/TDI for the next period are set on the edge that drives TCK low
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tms_d   = tms_q;
      tdi_d   = tdi_q;
      end_d   = 1'b0;
      case (state_q)
         TLR: begin
            if (end_q) begin
               state_d = IDLE;
            end else if (fall_tick) begin
               if (cnt_q == CNT_W'(TLR_LEN - 1)) begin
                  end_d = 1'b1;
               end else begin
                  cnt_d = nxt;
                  tms_d = (nxt < CNT_W'(TLR_LEN - 1));
               end
            end
         end
         IDLE: begin
            if (bus.cmd_valid) begin
               cnt_d = '0;
               if (len_clamped == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = HDR;
                  tms_d   = hdr_tms(bus.cmd_ir, 2'd0);
               end
            end
         end
         HDR: begin
            if (fall_tick) begin
               if (cnt_q == CNT_W'(hdr_last(ir_q))) begin
                  state_d = SHIFT;
                  cnt_d   = '0;
                  tms_d   = (len_ext == CNT_W'(1));
                  tdi_d   = sh_q[0];
               end else begin
                  cnt_d = nxt;
                  tms_d = hdr_tms(ir_q, nxt[1:0]);
               end
            end
         end
         SHIFT: begin
            if (fall_tick) begin
               if (cnt_q == len_ext - 1'b1) begin
                  state_d = TAIL;
                  cnt_d   = '0;
                  tms_d   = 1'b1;
               end else begin
                  cnt_d = nxt;
                  tms_d = (nxt == len_ext - 1'b1);
                  tdi_d = sh_q[0];
               end
            end
         end
         TAIL: begin
            if (end_q) begin
               state_d = DONE;
            end else if (fall_tick) begin
               if (cnt_q == CNT_W'(TAIL_LEN - 1)) begin
                  end_d = 1'b1;
               end else begin
                  cnt_d = nxt;
                  tms_d = 1'b0;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = TLR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_q  <= 1'b0;
         len_q <= '0;
         sh_q  <= '0;
         cap_q <= '0;
         rsp_q <= '0;
      end else begin
         if (accept) begin
            ir_q  <= bus.cmd_ir;
            len_q <= len_clamped;
            sh_q  <= bus.cmd_data;
            cap_q <= '0;
         end else begin
            if (fall_tick && state_d == SHIFT) sh_q <= sh_q >> 1;
            if (rise_tick && state_q == SHIFT) cap_q <= cap_q | (MAX_LEN'(tdo) << cnt_q);
         end
         // a zero-length scan reaches DONE straight from IDLE and reports nothing captured
         if (state_d == DONE && state_q != DONE)
            rsp_q <= (state_q == IDLE) ? '0 : cap_q;
      end
   end

endmodule

// File: tb/tb_jtag_driver.sv
// Directed bench for jtag_driver against a behavioural IEEE 1149.1 TAP with IDCODE and BYPASS.
module tb_jtag_driver;

   localparam int MAX_LEN = 32;
   localparam int CLK_DIV = 4;
   localparam logic [31:0] IDC    = 32'h4BA0_0477;
   localparam logic [3:0]  OP_IDC = 4'b0001;
   localparam logic [3:0]  OP_BYP = 4'b1111;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic tck, tms, tdi;
   logic tdo = 1'b0;

   always #5 clk = ~clk;

   jtag_driver_if #(.MAX_LEN(MAX_LEN)) bus ();

   jtag_driver #(.MAX_LEN(MAX_LEN), .CLK_DIV(CLK_DIV)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .tck   (tck),
      .tms   (tms),
      .tdi   (tdi),
      .tdo   (tdo)
   );

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- TAP model ----------------
   int          tap_st = 0;
   logic [3:0]  ir = OP_IDC;
   logic [3:0]  ir_sr = 4'b0;
   logic [31:0] dr_sr = 32'b0;
   logic        byp = 1'b0;
   int          tck_rises = 0;
   int          rsp_pulses = 0;
   logic        tms_log [256];
   logic        tdi_log [256];

   function automatic int tap_next(input int s, input logic m);
      case (s)
         0:  return m ? 0  : 1;
         1:  return m ? 2  : 1;
         2:  return m ? 9  : 3;
         3:  return m ? 5  : 4;
         4:  return m ? 5  : 4;
         5:  return m ? 8  : 6;
         6:  return m ? 7  : 6;
         7:  return m ? 8  : 4;
         8:  return m ? 2  : 1;
         9:  return m ? 0  : 10;
         10: return m ? 12 : 11;
         11: return m ? 12 : 11;
         12: return m ? 15 : 13;
         13: return m ? 14 : 13;
         14: return m ? 15 : 11;
         default: return m ? 2 : 1;
      endcase
   endfunction

   always @(posedge tck) begin
      tms_log[tck_rises & 255] = tms;
      tdi_log[tck_rises & 255] = tdi;
      tck_rises++;
      case (tap_st)
         0:  ir = OP_IDC;
         3:  begin dr_sr = IDC; byp = 1'b0; end
         4:  if (ir == OP_IDC) dr_sr = {tdi, dr_sr[31:1]}; else byp = tdi;
         10: ir_sr = 4'b0001;
         11: ir_sr = {tdi, ir_sr[3:1]};
         15: ir = ir_sr;
         default: ;
      endcase
      tap_st = tap_next(tap_st, tms);
   end

   always @(negedge tck) begin
      if (tap_st == 4)       tdo = (ir == OP_IDC) ? dr_sr[0] : byp;
      else if (tap_st == 11) tdo = ir_sr[0];
   end

   always @(posedge clk) if (bus.rsp_valid) rsp_pulses++;

   function automatic logic [63:0] tms_vec(input int b, input int n);
      logic [63:0] v = '0;
      for (int i = 0; i < n; i++) v[i] = tms_log[(b + i) & 255];
      return v;
   endfunction

   function automatic logic [63:0] tdi_vec(input int b, input int n);
      logic [63:0] v = '0;
      for (int i = 0; i < n; i++) v[i] = tdi_log[(b + i) & 255];
      return v;
   endfunction

   // Counts posedges from reset release (at a negedge) until cmd_ready is seen high.
   task automatic release_and_wait_ready(output int n, output int base);
      base  = tck_rises;
      rst_n = 1'b1;
      n = 0;
      while (!bus.cmd_ready && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic issue(input logic ir_s, input logic [5:0] len, input logic [31:0] data, output int base);
      int n = 0;
      @(negedge clk);
      while (!bus.cmd_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("ready_before_cmd", 64'(bus.cmd_ready), 64'd1);
      base          = tck_rises;
      bus.cmd_valid = 1'b1;
      bus.cmd_ir    = ir_s;
      bus.cmd_len   = len;
      bus.cmd_data  = data;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic scan(input string tag, input logic ir_s, input logic [5:0] len, input logic [31:0] data,
                       output logic [31:0] rsp, output int lat, output int rises, output int base);
      issue(ir_s, len, data, base);
      lat = 1;
      while (!bus.rsp_valid && lat < 4000) begin
         @(posedge clk); #1;
         lat++;
      end
      rsp   = bus.rsp_data;
      rises = tck_rises - base;
      @(posedge clk); #1;
      check({tag, "_rsp_one_cycle"}, 64'(bus.rsp_valid), 64'd0);
      check({tag, "_ready_after"},   64'(bus.cmd_ready), 64'd1);
      check({tag, "_rsp_held"},      64'(bus.rsp_data),  64'(rsp));
   endtask

   initial begin
      int n, base, lat, rises, pulses;
      logic [31:0] rsp;

      bus.cmd_valid = 1'b0;
      bus.cmd_ir    = 1'b0;
      bus.cmd_len   = '0;
      bus.cmd_data  = '0;

      // Reset values and the TLR sequence
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tck",       64'(tck),           64'd0);
      check("rst_tms",       64'(tms),           64'd1);
      check("rst_tdi",       64'(tdi),           64'd0);
      check("rst_ready",     64'(bus.cmd_ready), 64'd0);
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("rst_rsp_data",  64'(bus.rsp_data),  64'd0);
      release_and_wait_ready(n, base);
      check("tlr_ready_cycles", 64'(n),                 64'd49);
      check("tlr_rises",        64'(tck_rises - base),  64'd6);
      check("tlr_tms",          tms_vec(base, 6),       64'b011111);

      // IDCODE is selected after Test-Logic-Reset
      scan("dr_id", 1'b0, 6'd32, 32'h0, rsp, lat, rises, base);
      check("dr_id_data",  64'(rsp),   64'(IDC));
      check("dr_id_rises", 64'(rises), 64'd37);
      check("dr_id_lat",   64'(lat),   64'd298);

      // IR scan of 4'b0001: header 1,1,0,0 / shift 0,0,0,1 / tail 1,0
      scan("ir_idc", 1'b1, 6'd4, 32'h1, rsp, lat, rises, base);
      check("ir_idc_capture", 64'(rsp),            64'h1);
      check("ir_idc_rises",   64'(rises),          64'd10);
      check("ir_idc_lat",     64'(lat),            64'd82);
      check("ir_idc_tms",     tms_vec(base, 10),   64'h183);
      check("ir_idc_tdi",     tdi_vec(base + 4, 4), 64'h1);

      // Select BYPASS, then an 8-bit DR scan sees a one-bit delay
      scan("ir_byp", 1'b1, 6'd4, 32'hF, rsp, lat, rises, base);
      check("ir_byp_capture", 64'(rsp), 64'h1);
      check("ir_byp_tap_ir",  64'(ir),  64'(OP_BYP));
      scan("dr_byp", 1'b0, 6'd8, 32'hA5, rsp, lat, rises, base);
      check("dr_byp_data",  64'(rsp),             64'h4A);
      check("dr_byp_rises", 64'(rises),           64'd13);
      check("dr_byp_lat",   64'(lat),             64'd106);
      check("dr_byp_tms",   tms_vec(base, 13),    64'hC01);
      check("dr_byp_tdi",   tdi_vec(base + 3, 8), 64'hA5);

      // Zero-length scan: no TCK activity, immediate DONE, response cleared
      scan("len0", 1'b0, 6'd0, 32'hFFFF_FFFF, rsp, lat, rises, base);
      check("len0_data",  64'(rsp),   64'h0);
      check("len0_rises", 64'(rises), 64'd0);
      check("len0_lat",   64'(lat),   64'd1);

      // Over-long request is clamped to a 32-bit shift
      scan("len40", 1'b0, 6'd40, 32'hDEAD_BEEF, rsp, lat, rises, base);
      check("len40_data",  64'(rsp),   64'hBD5B_7DDE);
      check("len40_rises", 64'(rises), 64'd37);
      check("len40_lat",   64'(lat),   64'd298);

      // Reset in the middle of a 16-bit shift
      issue(1'b0, 6'd16, 32'h0000_1234, base);
      n = 0;
      while ((tck_rises - base) < 8 && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      check("mid_tck_high", 64'(tck), 64'd1);
      pulses = rsp_pulses;
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_tck",   64'(tck),           64'd0);
      check("mid_rst_tms",   64'(tms),           64'd1);
      check("mid_rst_ready", 64'(bus.cmd_ready), 64'd0);
      repeat (2) @(negedge clk);
      release_and_wait_ready(n, base);
      check("mid_tlr_ready_cycles", 64'(n),                64'd49);
      check("mid_tlr_tms",          tms_vec(base, 6),      64'b011111);
      check("mid_no_rsp",           64'(rsp_pulses),       64'(pulses));
      scan("post_rst", 1'b0, 6'd32, 32'h0, rsp, lat, rises, base);
      check("post_rst_data",  64'(rsp),   64'(IDC));
      check("post_rst_rises", 64'(rises), 64'd37);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
